alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the shared n-bit ALU and register-transfer bus.
//  Accepts one 9-bit instruction at a time over a valid/ready handshake.
//  Drives ALU op/add-sub/carry-in, bus mux select, A/G latch enables and register write enables.
//  Sits between instruction source and datapath (8-register file, A reg, ALU, G reg).
// PARAMETERS
//  N  8  datapath width (immediate width, must match ALU n)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high reset
//  instr_valid      in   1   instruction offered
//  instr            in   9   [8:6] opcode, [5:3] rx, [2:0] ry
//  imm              in   N   immediate for MVI, sampled with instr
//  instr_ready      out  1   high only in IDLE (and reset low)
//  alu_cout         in   1   ALU carry out
//  bus_sel          out  4   0-7 = Rk, 8 = G, 9 = imm register, 15 = none
//  imm_out          out  N   registered immediate
//  r_in             out  8   one-hot register write enables
//  a_in             out  1   load A from bus
//  g_in             out  1   load G from ALU output
//  alu_op           out  2   00 add/sub, 01 and
//  add_sub_control  out  1   1 = subtract (invert y)
//  cin              out  1   ALU carry in
//  done             out  1   one-cycle pulse, instruction retired
//  busy             out  1   state != IDLE
//  carry_flag       out  1   latched carry (0 when feature off)
// BEHAVIOUR
//  - Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 AND, 101 ADC (feature), others NOP.
//  - States: IDLE, T1, T2, T3. Accept = instr_valid & instr_ready at a clock edge:
//    IR <= instr, imm register <= imm, state -> T1.
//  - MV  T1: bus_sel=ry, r_in[rx]=1, done=1 -> IDLE.
//  - MVI T1: bus_sel=9, r_in[rx]=1, done=1 -> IDLE.
//  - ALU ops: T1: bus_sel=rx, a_in=1 -> T2.
//    T2: bus_sel=ry, g_in=1, alu_op/add_sub_control/cin per op -> T3.
//    T3: bus_sel=8, r_in[rx]=1, done=1 -> IDLE.
//  - ADD: op 00, sub 0, cin 0. SUB: op 00, sub 1, cin 1 (two's complement). AND: op 01, sub 0, cin 0.
//  - NOP: T1 with done=1, no enables -> IDLE.
//  - Latency accept->done: 1 cycle (MV, MVI, NOP), 3 cycles (ALU ops). instr_ready high the cycle after done.
//  - Back-to-back: max throughput one instruction per 2 cycles (MV) or per 4 cycles (ALU).
//  - Control outputs decode from registered state+IR. Outside the active state:
//    bus_sel=15, all enables/ALU controls/done = 0.
//  - Register aliasing (rx == ry) is legal: A captures old Rx before the write in T3.
//  - instr_valid in non-IDLE states is ignored (no queuing).
//  - Reset (async, any time incl. mid-instruction): state=IDLE, IR=0, imm register=0,
//    carry_flag=0, all control outputs at idle values, instr_ready=0 while reset is high.
//    An in-flight instruction is dropped with no write-back.
// CONFIGURATION
//  CARRY_FLAG_EN defined:
//   - carry_flag <= alu_cout at the T2 edge of ADD/SUB/ADC; AND clears it.
//   - ADC (101): as ADD but cin=carry_flag.
//  CARRY_FLAG_EN undefined:
//   - no flag register; carry_flag tied 0; alu_cout ignored; 101 decodes as NOP.
// TESTING
//  1 Reset, then MVI r2,0x5A -> done at accept+1, bus_sel=9, r_in=8'h04, imm_out=0x5A.
//  2 ADD r1,r3 -> T1 bus_sel=1 a_in; T2 bus_sel=3 g_in, op 00 sub 0 cin 0; T3 bus_sel=8 r_in=8'h02 done.
//  3 SUB r0,r0 -> T2 add_sub_control=1, cin=1; done at accept+3; instr_ready=1 at accept+4.
//  4 instr_valid held high with MV,ADD,AND stream -> accepts only in IDLE, dones at correct cycles, no lost/duplicate instr.
//  5 reset asserted in T2 of ADD -> outputs idle immediately (async), no r_in pulse, next instr starts cleanly.
//  6 CARRY_FLAG_EN: ADD with alu_cout=1 -> carry_flag=1; ADC -> cin=1 in T2; without macro ADC -> NOP, done at accept+1.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Instruction handshake and datapath control bundle for alu_sequencer.
// The sequencer takes the slave modport; the instruction source/datapath takes master.
interface alu_sequencer_if #(
    parameter int N = 8
);
    logic         instr_valid;
    logic [8:0]   instr;
    logic [N-1:0] imm;
    logic         instr_ready;
    logic         alu_cout;
    logic [3:0]   bus_sel;
    logic [N-1:0] imm_out;
    logic [7:0]   r_in;
    logic         a_in;
    logic         g_in;
    logic [1:0]   alu_op;
    logic         add_sub_control;
    logic         cin;
    logic         done;
    logic         busy;
    logic         carry_flag;

    modport master (
        output instr_valid, instr, imm, alu_cout,
        input  instr_ready, bus_sel, imm_out, r_in, a_in, g_in, alu_op,
               add_sub_control, cin, done, busy, carry_flag
    );

    modport slave (
        input  instr_valid, instr, imm, alu_cout,
        output instr_ready, bus_sel, imm_out, r_in, a_in, g_in, alu_op,
               add_sub_control, cin, done, busy, carry_flag
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM sequencing a shared ALU, A/G registers and register bus.
// Optional CARRY_FLAG_EN adds a latched carry flag and the ADC instruction.
module alu_sequencer #(
    parameter int N = 8
) (
    input logic            clock,
    input logic            reset,
    alu_sequencer_if.slave ctl
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;

    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_IMM  = 4'd9;
    localparam logic [3:0] SEL_NONE = 4'd15;

    state_t       state, state_next;
    logic [8:0]   ir;
    logic [N-1:0] imm_q;
    logic         carry_q;
    logic         accept;
    logic         is_alu;
    logic [2:0]   opcode, rx, ry;

    logic [3:0]   bus_sel;
    logic [7:0]   r_in;
    logic         a_in, g_in, add_sub, cin, done;
    logic [1:0]   alu_op;

    assign opcode = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];
    assign accept = ctl.instr_valid & ctl.instr_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
            imm_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ir    <= ctl.instr;
                imm_q <= ctl.imm;
            end
        end
    end

`ifdef CARRY_FLAG_EN
    // The flag is captured on the edge that leaves T2, alongside G.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (state == T2) begin
            if (opcode == OP_AND) carry_q <= 1'b0;
            else                  carry_q <= ctl.alu_cout;
        end
    end

    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_ADC);
`else
    assign carry_q = 1'b0;
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND);
`endif

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        bus_sel    = SEL_NONE;
        r_in       = '0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        alu_op     = 2'b00;
        add_sub    = 1'b0;
        cin        = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) state_next = T1;
            end
            T1: begin
                if (opcode == OP_MV) begin
                    bus_sel    = {1'b0, ry};
                    r_in       = 8'd1 << rx;
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (opcode == OP_MVI) begin
                    bus_sel    = SEL_IMM;
                    r_in       = 8'd1 << rx;
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (is_alu) begin
                    bus_sel    = {1'b0, rx};
                    a_in       = 1'b1;
                    state_next = T2;
                end else begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            T2: begin
                bus_sel    = {1'b0, ry};
                g_in       = 1'b1;
                state_next = T3;
                case (opcode)
                    OP_SUB: begin
                        add_sub = 1'b1;
                        cin     = 1'b1;
                    end
                    OP_AND:  alu_op = 2'b01;
                    OP_ADC:  cin    = carry_q;
                    default: ;
                endcase
            end
            T3: begin
                bus_sel    = SEL_G;
                r_in       = 8'd1 << rx;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ctl.instr_ready     = (state == IDLE) & ~reset;
    assign ctl.busy            = (state != IDLE);
    assign ctl.bus_sel         = bus_sel;
    assign ctl.imm_out         = imm_q;
    assign ctl.r_in            = r_in;
    assign ctl.a_in            = a_in;
    assign ctl.g_in            = g_in;
    assign ctl.alu_op          = alu_op;
    assign ctl.add_sub_control = add_sub;
    assign ctl.cin             = cin;
    assign ctl.done            = done;
    assign ctl.carry_flag      = carry_q;
endmodule
